// File: rtl/count_pkg.sv
// Shared types and helpers for the count-stream generator and its receiver-side checker.
package count_pkg;

  localparam int unsigned DEFAULT_WIDTH = 2;
  localparam int unsigned MAX_COUNT_W   = 16;

  // 2-bit encoding is fully populated; also exposed for debug visibility.
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    SLIP    = 2'd3
  } state_e;

  // value+1 modulo 2^width
  function automatic logic [MAX_COUNT_W-1:0] next_count(input logic [MAX_COUNT_W-1:0] value,
                                                        input int unsigned            width);
    logic [MAX_COUNT_W-1:0] mask;
    mask = MAX_COUNT_W'((32'd1 << width) - 32'd1);
    return (value + MAX_COUNT_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/count_seq_checker_if.sv
// Sample input and status output bundle of the sequence checker.
interface count_seq_checker_if
  import count_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned ERR_CNT_W = 8
);

  logic                 in_valid;
  logic [WIDTH-1:0]     in_count;
  logic                 clear_err;
  logic                 locked;
  logic                 err_pulse;
  logic                 wrap_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [WIDTH-1:0]     expected;

  modport master (
    output in_valid, in_count, clear_err,
    input  locked, err_pulse, wrap_pulse, err_count, expected
  );

  modport slave (
    input  in_valid, in_count, clear_err,
    output locked, err_pulse, wrap_pulse, err_count, expected
  );

endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with inc yields 1.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= W'(inc);
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_checker.sv
// Receiver-side lock/slip monitor for a free-running modulo-2^WIDTH count stream.
module count_seq_checker
  import count_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned LOCK_CNT    = 2,
  parameter int unsigned UNLOCK_ERRS = 2,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  count_seq_checker_if.slave  bus
);

  localparam int unsigned RUN_W = 4;
  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [RUN_W-1:0] LOCK_LAST   = RUN_W'(LOCK_CNT - 1);
  localparam logic [RUN_W-1:0] UNLOCK_LAST = RUN_W'(UNLOCK_ERRS - 1);

  state_e           state;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] bad_run;
  logic [WIDTH-1:0] expected;
  logic             locked;
  logic             err_pulse;
  logic             wrap_pulse;

  logic             match_c;
  logic             err_inc_c;
  logic [WIDTH-1:0] in_next_c;
  logic [WIDTH-1:0] exp_next_c;

  always_comb begin
    match_c    = (bus.in_count == expected);
    in_next_c  = WIDTH'(next_count(MAX_COUNT_W'(bus.in_count), WIDTH));
    exp_next_c = WIDTH'(next_count(MAX_COUNT_W'(expected), WIDTH));
    err_inc_c  = bus.in_valid && !match_c && ((state == LOCKED) || (state == SLIP));
  end

  // Lock FSM; expected flywheels through errors once locked instead of resyncing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      good_run   <= '0;
      bad_run    <= '0;
      expected   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      if (bus.in_valid) begin
        case (state)
          HUNT: begin
            expected <= in_next_c;
            good_run <= '0;
            state    <= ACQUIRE;
          end
          ACQUIRE: begin
            if (match_c) begin
              expected <= exp_next_c;
              good_run <= good_run + RUN_W'(1);
              if (good_run == LOCK_LAST) begin
                state   <= LOCKED;
                locked  <= 1'b1;
                bad_run <= '0;
              end
            end else begin
              expected <= in_next_c;
              good_run <= '0;
            end
          end
          LOCKED: begin
            expected <= exp_next_c;
            if (match_c) begin
              wrap_pulse <= (bus.in_count == MAX_VAL);
            end else begin
              err_pulse <= 1'b1;
              bad_run   <= RUN_W'(1);
              if (UNLOCK_ERRS == 1) begin
                state  <= HUNT;
                locked <= 1'b0;
              end else begin
                state <= SLIP;
              end
            end
          end
          SLIP: begin
            expected <= exp_next_c;
            if (match_c) begin
              wrap_pulse <= (bus.in_count == MAX_VAL);
              bad_run    <= '0;
              state      <= LOCKED;
            end else begin
              err_pulse <= 1'b1;
              bad_run   <= bad_run + RUN_W'(1);
              if (bad_run == UNLOCK_LAST) begin
                state  <= HUNT;
                locked <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clear_err),
    .inc   (err_inc_c),
    .count (bus.err_count)
  );

  assign bus.locked     = locked;
  assign bus.err_pulse  = err_pulse;
  assign bus.wrap_pulse = wrap_pulse;
  assign bus.expected   = expected;

endmodule
